// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: program counter, instruction-ROM word address,
// and the IF/ID pipeline register, with stall, flush, redirect and a sticky
// fetch fault. Optional performance counters are enabled by defining
// FETCH_PERF_CNT_EN.
module mips_fetch_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [31:0]           pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [31:0]           if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           stall_count_o
`endif
);

    localparam int unsigned WORD_OFF_W = 30;

    logic [WORD_OFF_W-1:0] off_word;
    logic                  pc_invalid;
    logic [31:0]           pc_plus4;

    logic [31:0]           pc_d;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [31:0]           pc4_d;
    logic                  valid_d;
    logic                  fault_d;
    logic                  fetch_ok;
    logic                  stall_cnt_en;

    // Word offset of the PC from the ROM base; wrap-around catches pc < RESET_PC.
    always_comb begin
        off_word   = WORD_OFF_W'((pc_o - RESET_PC) >> 2);
        rom_addr_o = off_word[ADDR_WIDTH-1:0];
        pc_invalid = (|pc_o[1:0]) | (|off_word[WORD_OFF_W-1:ADDR_WIDTH]);
        pc_plus4   = pc_o + 32'd4;
    end

    // Next-state selection: redirect > flush > stall > normal fetch.
    always_comb begin
        pc_d         = pc_o;
        instr_d      = if_id_instr_o;
        pc4_d        = if_id_pc_plus4_o;
        valid_d      = if_id_valid_o;
        fault_d      = fault_o;
        fetch_ok     = 1'b0;
        stall_cnt_en = stall_i & ~redirect_i;

        if (redirect_i) begin
            pc_d    = redirect_pc_i;
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (flush_i) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            if (!stall_i) begin
                pc_d = pc_plus4;
            end
        end else if (!stall_i) begin
            pc_d = pc_plus4;
            if (pc_invalid) begin
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                instr_d  = rom_data_i;
                pc4_d    = pc_plus4;
                valid_d  = 1'b1;
                fetch_ok = 1'b1;
            end
        end
    end

    // PC, IF/ID and fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_o             <= RESET_PC;
            if_id_instr_o    <= '0;
            if_id_pc_plus4_o <= '0;
            if_id_valid_o    <= 1'b0;
            fault_o          <= 1'b0;
        end else begin
            pc_o             <= pc_d;
            if_id_instr_o    <= instr_d;
            if_id_pc_plus4_o <= pc4_d;
            if_id_valid_o    <= valid_d;
            fault_o          <= fault_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Fetch and stall event counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_o <= '0;
            stall_count_o <= '0;
        end else begin
            if (fetch_ok) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            if (stall_cnt_en) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_ok ^ stall_cnt_en;
`endif

endmodule
